// File: rtl/d_debounce_pkg.sv
// Shared types and constants for the d_debounce input-conditioning stage.
package d_debounce_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_e;

  localparam int GLITCH_CNT_W    = 16;
  localparam int MIN_SYNC_STAGES = 2;

endpackage : d_debounce_pkg

// File: rtl/d_sync.sv
// Plain flop-chain synchronizer with an asynchronous active-low reset value.
module d_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Pure shift chain; nothing may sit between the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule : d_sync

// File: rtl/d_debounce.sv
// Synchronize and debounce an asynchronous level; emit clean q plus rise/fall pulses.
// Define D_DEBOUNCE_STATS_EN to add the saturating glitch_cnt rejection counter.
module d_debounce
  import d_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  input  logic [CNT_W-1:0]        threshold,
`ifdef D_DEBOUNCE_STATS_EN
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic                    q,
  output logic                    rise,
  output logic                    fall,
  output logic                    busy
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("d_debounce: SYNC_STAGES must be at least MIN_SYNC_STAGES");
  end

  logic             w_s;
  logic [CNT_W-1:0] w_thr_eff;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;

  d_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (din),
    .o_q   (w_s)
  );

  assign w_thr_eff = (threshold == '0) ? CNT_W'(1) : threshold;

  // NOTE: every register here uses <= so all updates see pre-edge values of s, q and cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_q     <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      unique case (r_state)
        ST_STABLE: begin
          if (w_s != r_q) begin
            r_state <= ST_QUALIFY;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end else begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_QUALIFY: begin
          if (w_s == r_q) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt >= w_thr_eff) begin
            // Commit; the return to STABLE blocks a new candidate this cycle.
            r_q     <= w_s;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef D_DEBOUNCE_STATS_EN
  logic [GLITCH_CNT_W-1:0] r_glitch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if ((r_state == ST_QUALIFY) && (w_s == r_q) && (r_glitch_cnt != '1)) begin
      r_glitch_cnt <= r_glitch_cnt + GLITCH_CNT_W'(1);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;
  assign busy = r_busy;

endmodule : d_debounce

// File: tb/tb_d_debounce.sv
// Self-checking bench for d_debounce: table-driven transitions plus reset and threshold corner cases.
module tb_d_debounce;

  localparam int S = 2;

  typedef struct {
    logic q;
    logic rise;
    logic fall;
    logic busy;
  } exp_t;

  typedef struct {
    logic       from_lvl;
    logic       to_lvl;
    logic [7:0] thr;
    logic       held;
    int         hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [7:0]  threshold;
  logic        q, rise, fall, busy;
`ifdef D_DEBOUNCE_STATS_EN
  logic [15:0] glitch_cnt;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  d_debounce #(
    .SYNC_STAGES (S),
    .CNT_W       (8),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .threshold  (threshold),
`ifdef D_DEBOUNCE_STATS_EN
    .glitch_cnt (glitch_cnt),
`endif
    .q          (q),
    .rise       (rise),
    .fall       (fall),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, " q"},    {15'd0, q},    {15'd0, e.q});
    check({tag, " rise"}, {15'd0, rise}, {15'd0, e.rise});
    check({tag, " fall"}, {15'd0, fall}, {15'd0, e.fall});
    check({tag, " busy"}, {15'd0, busy}, {15'd0, e.busy});
  endtask

  // Drive din for one edge, queue what the outputs should be after it, then compare.
  task automatic step(input logic d, input exp_t e, input string tag);
    din = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front(tag);
  endtask

  task automatic sample_now(input exp_t e, input string tag);
    sb.push_back(e);
    compare_front(tag);
  endtask

  // Expected outputs follow from the edge-numbered timing: the FSM sees the new level
  // on edges S+1 .. hold+S; commit lands on edge S+1+thr_eff if the level lasts.
  task automatic run_vec(input vec_t v, input int idx);
    int   thr_eff, ce, n_edges;
    bit   committed;
    exp_t e;
    logic d;
    thr_eff   = (v.thr == 8'd0) ? 1 : int'(v.thr);
    ce        = S + 1 + thr_eff;
    committed = v.held || (v.hold >= thr_eff + 1);
    n_edges   = committed ? ce + 3 : v.hold + S + 4;
    threshold = v.thr;
    for (int k = 1; k <= n_edges; k++) begin
      d = (v.held || k <= v.hold) ? v.to_lvl : v.from_lvl;
      if (committed) begin
        e.q    = (k >= ce) ? v.to_lvl : v.from_lvl;
        e.rise = (k == ce) && v.to_lvl;
        e.fall = (k == ce) && !v.to_lvl;
        e.busy = (k >= S + 1) && (k < ce);
      end else begin
        e.q    = v.from_lvl;
        e.rise = 1'b0;
        e.fall = 1'b0;
        e.busy = (k >= S + 1) && (k <= v.hold + S);
      end
      step(d, e, $sformatf("vec%0d edge%0d", idx, k));
    end
  endtask

  vec_t vecs[7];

  initial begin
    exp_t z, e;
    z = '{q: 1'b0, rise: 1'b0, fall: 1'b0, busy: 1'b0};

    vecs[0] = '{from_lvl: 1'b1, to_lvl: 1'b0, thr: 8'd0, held: 1'b1, hold: 0};
    vecs[1] = '{from_lvl: 1'b0, to_lvl: 1'b1, thr: 8'd4, held: 1'b0, hold: 2};
    vecs[2] = '{from_lvl: 1'b0, to_lvl: 1'b1, thr: 8'd4, held: 1'b1, hold: 0};
    vecs[3] = '{from_lvl: 1'b1, to_lvl: 1'b0, thr: 8'd3, held: 1'b0, hold: 3};
    vecs[4] = '{from_lvl: 1'b1, to_lvl: 1'b0, thr: 8'd3, held: 1'b1, hold: 0};
    vecs[5] = '{from_lvl: 1'b0, to_lvl: 1'b1, thr: 8'd2, held: 1'b0, hold: 1};
    vecs[6] = '{from_lvl: 1'b0, to_lvl: 1'b1, thr: 8'd1, held: 1'b1, hold: 0};

    // Reset with din held high: outputs quiet during reset, rise at edge 7 after release.
    rst_n     = 1'b0;
    din       = 1'b1;
    threshold = 8'd4;
    #1;
    sample_now(z, "reset t0");
    for (int k = 0; k < 3; k++) step(1'b1, z, $sformatf("in reset %0d", k));
`ifdef D_DEBOUNCE_STATS_EN
    check("glitch_cnt reset", glitch_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    run_vec('{from_lvl: 1'b0, to_lvl: 1'b1, thr: 8'd4, held: 1'b1, hold: 0}, 99);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

`ifdef D_DEBOUNCE_STATS_EN
    check("glitch_cnt after table", glitch_cnt, 16'd3);
`endif

    // Threshold lowered from 10 to 2 while cnt = 5: commit on the very next edge.
    threshold = 8'd10;
    for (int k = 1; k <= 7; k++) begin
      e = '{q: 1'b1, rise: 1'b0, fall: 1'b0, busy: (k >= 3)};
      step(1'b0, e, $sformatf("thr drop edge%0d", k));
    end
    threshold = 8'd2;
    step(1'b0, '{q: 1'b0, rise: 1'b0, fall: 1'b1, busy: 1'b0}, "thr drop commit");
    step(1'b0, z, "thr drop after");
    step(1'b0, z, "thr drop idle");

    // Reset asserted mid-QUALIFY with cnt = 3: immediate clear and no pulses around it.
    threshold = 8'd10;
    for (int k = 1; k <= 5; k++) begin
      e = '{q: 1'b0, rise: 1'b0, fall: 1'b0, busy: (k >= 3)};
      step(1'b1, e, $sformatf("pre reset edge%0d", k));
    end
    #2;
    rst_n = 1'b0;
    #1;
    sample_now(z, "mid qualify reset");
    step(1'b0, z, "held reset a");
    step(1'b0, z, "held reset b");
`ifdef D_DEBOUNCE_STATS_EN
    check("glitch_cnt cleared", glitch_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0, z, $sformatf("post reset %0d", k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_d_debounce
